// File: rtl/sdram_load_writer.sv
// sdram_load_writer: ram_clk-domain write adapter between the ROM loader and
// the SDRAM controller load port. Loader bytes arrive as toggle requests, are
// paired into 16-bit words where possible, buffered in a small FIFO and issued
// to the controller one at a time.
//
// Handshakes:
//   loader side : a change on ld_toggle is one request; ld_addr/ld_data/ld_be
//                 are held stable until ld_rdy pulses for one cycle, which
//                 marks the byte as taken.
//   sdram side  : sdr_req is a level; sdr_addr/sdr_data/sdr_be are stable
//                 while it is high. A one-cycle sdr_ack completes the write;
//                 the next word (if any) appears in the following cycle with
//                 sdr_req still high. sdr_ack while sdr_req is low is ignored.
//
// FIFO_DEPTH must be a power of two and at least 2.
module sdram_load_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_FLUSH = 63
) (
  input  logic        ram_clk,
  input  logic        reset_n,
  input  logic        ld_toggle,
  input  logic [24:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic [1:0]  ld_be,
  output logic        ld_rdy,
  input  logic        flush,
  output logic        busy,
  output logic        sdr_req,
  output logic [23:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  input  logic        sdr_ack,
  output logic        port_state_dbg
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  IDLE_LIMIT = 6'(IDLE_FLUSH);

  typedef struct packed {
    logic [23:0] waddr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Byte address bit 0 is redundant with ld_be.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ld_addr[0];

  // ---------------------------------------------------------------------
  // Request synchroniser and acceptance
  // ---------------------------------------------------------------------
  logic s1, s2, seen;
  logic req_seen;
  logic pend_v;
  wr_t  pend;
  logic mergeable;
  logic can_push;
  logic accept;
  logic acc_push;
  logic idle_due;
  logic idle_push;
  logic fifo_push;
  wr_t  push_data;
  logic [5:0] idle_cnt;
  logic flush_lat;

  logic [AW:0] wr_ptr, rd_ptr;
  wr_t         fifo_mem [FIFO_DEPTH];
  wr_t         fifo_head;
  logic        fifo_full, fifo_empty, fifo_pop;

  state_t state, state_nxt;
  logic   load_out;

  assign req_seen  = s2 ^ seen;
  assign mergeable = pend_v && (pend.be == 2'b01) && (ld_be == 2'b10) &&
                     (pend.waddr == ld_addr[24:1]);
  // A pop in the same cycle frees a slot even when the FIFO is full.
  assign can_push  = !fifo_full || fifo_pop;
  // Loading into an empty pending register never pushes, so it never stalls.
  assign accept    = req_seen && (!pend_v || can_push);
  assign acc_push  = accept && pend_v;
  assign idle_due  = pend_v && ((idle_cnt == IDLE_LIMIT) || flush_lat);
  // Acceptance wins; a replace push already empties the old pending byte.
  assign idle_push = idle_due && !accept && can_push;
  assign fifo_push = acc_push || idle_push;
  assign push_data = (accept && mergeable) ?
                     '{waddr: pend.waddr, data: {ld_data[15:8], pend.data[7:0]}, be: 2'b11} :
                     pend;

  // Two-flop toggle synchroniser, seen-state tracking and ld_rdy pulse.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      seen   <= 1'b0;
      ld_rdy <= 1'b0;
    end else begin
      s1     <= ld_toggle;
      s2     <= s1;
      ld_rdy <= accept;
      if (accept) seen <= s2;
    end
  end

  // Pending byte register: merge clears it, replace/load refill it, idle push empties it.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v <= 1'b0;
      pend   <= '0;
    end else if (accept) begin
      if (mergeable) begin
        pend_v <= 1'b0;
      end else begin
        pend_v <= 1'b1;
        pend   <= '{waddr: ld_addr[24:1], data: ld_data, be: ld_be};
      end
    end else if (idle_push) begin
      pend_v <= 1'b0;
    end
  end

  // Idle counter (saturating at the limit) and the latched flush request.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt  <= '0;
      flush_lat <= 1'b0;
    end else begin
      if (accept || idle_push || !pend_v)
        idle_cnt <= '0;
      else if (!req_seen && (idle_cnt != IDLE_LIMIT))
        idle_cnt <= idle_cnt + 6'd1;
      flush_lat <= (flush_lat || flush) && pend_v && !idle_push;
    end
  end

  // ---------------------------------------------------------------------
  // Write FIFO: extra wrap bit distinguishes full from empty
  // ---------------------------------------------------------------------
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  // FIFO read/write pointers.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge ram_clk) begin
    if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // ---------------------------------------------------------------------
  // SDRAM port FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, FIFO pop and output-load decisions.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_out  = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdr_ack) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load_out = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output word registers; only reloaded when a new head is issued.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      sdr_addr <= '0;
      sdr_data <= '0;
      sdr_be   <= '0;
    end else if (load_out) begin
      sdr_addr <= fifo_head.waddr;
      sdr_data <= fifo_head.data;
      sdr_be   <= fifo_head.be;
    end
  end

  assign sdr_req        = (state == ST_REQ);
  assign busy           = pend_v || !fifo_empty || sdr_req;
  assign port_state_dbg = logic'(state);

endmodule
